seg_digit_scanner: RTL and testbench
====================================

# seg_digit_scanner

- Time-multiplexes a four-character message onto a single shared 7-segment display.
- Sits directly upstream of `LEDdecoder`:
  - drives its 4-bit `char` input;
  - drives the common anodes of the four display digits.
- Messages come from the receiver datapath through a valid/ready handshake and are double-buffered, so a new message only appears at a frame boundary.
- Each digit slot starts with a short blanking window to suppress ghosting while the decoder output settles.

## Interface

**Parameters**
- `DIGIT_CYCLES`, default 1000: clock cycles per digit slot. Must be ≥ 2.
- `BLANK_CYCLES`, default 4: cycles at the start of each slot with all anodes off. Must satisfy 1 ≤ `BLANK_CYCLES` < `DIGIT_CYCLES`.

**Ports**
- `clk`, input, 1: single clock. Everything is on its rising edge.
- `reset`, input, 1: reset is synchronous and active-high.
- `msg_in`, input, 16: four chars, `[15:12]` = leftmost digit 3 through `[3:0]` = digit 0. Char codes: 0–9 digits, 10 '-', 11 'F', 12 space. Codes 13–15 are passed through unchanged.
- `msg_valid`, input, 1: `msg_in` is offered.
- `msg_ready`, output, 1: pending buffer is empty; a message is accepted on `msg_valid && msg_ready`.
- `char`, output, 4: code for the currently selected digit; goes to `LEDdecoder`.
- `an`, output, 4: anode enables, active-low, one-hot-low when lit, `an[i]` = digit i.
- `frame_start`, output, 1: one-cycle pulse on the first cycle of each new frame.

## Operation

**State**
- `cnt`: 0..`DIGIT_CYCLES`-1, slot cycle counter.
- `idx`: 0..3, current digit.
- `disp[15:0]`: displayed message.
- `pend[15:0]` plus `pend_full`: pending message buffer.
- `frame_start` register.

**Reset values** (applied on a clock edge with `reset`=1)
- `cnt`=0, `idx`=3
- `disp`=16'hCCCC (all spaces), `pend_full`=0
- `frame_start`=0, `msg_ready`=1
- `char`=4'hC, `an`=4'b1111
- Reset mid-frame or mid-handshake discards the pending message and the scan position.

**Scan**
- `cnt` increments every cycle.
- At `cnt`=`DIGIT_CYCLES`-1, `cnt` wraps to 0 and `idx` steps down: 3→2→1→0→3.

**Output decode** (Moore; no combinational path from inputs)
- `char` = `disp[4*idx+3 : 4*idx]` for the whole slot, including the blank window.
- `an` = 4'b1111 while `cnt` < `BLANK_CYCLES`.
- Otherwise `an` = ~(1 << `idx`).

**Handshake**
- `msg_ready` = !`pend_full`.
- On an edge with `msg_valid && msg_ready`: `pend` ← `msg_in`, `pend_full` ← 1.
- `msg_in` is ignored when `msg_ready`=0. Dropped offers are the sender's responsibility; it must hold `msg_valid`.

**Frame boundary (wrap edge)**
- The wrap edge is the edge where `idx`=0 and `cnt`=`DIGIT_CYCLES`-1.
- On that edge, `frame_start` ← 1; on all other edges it is ← 0.
- If `pend_full` on that edge: `disp` ← `pend`, `pend_full` ← 0.
- A message accepted on the wrap edge itself is not promoted. It waits for the next frame.
- No promotion ever happens outside a wrap edge, so a frame is never torn.

## Timing

- Frame period = 4 × `DIGIT_CYCLES` cycles. Each digit is lit for `DIGIT_CYCLES` − `BLANK_CYCLES` cycles.
- First cycle after reset release: `idx`=3, `cnt`=0, `an`=1111, `frame_start`=0. The first frame after reset has no pulse.
- `frame_start`=1 coincides with `cnt`=0, `idx`=3 and the newly promoted `disp`.
- Accept-to-display latency:
  - best case 1 cycle, when accepted exactly one edge before the wrap edge;
  - worst case 4 × `DIGIT_CYCLES` cycles, when accepted on the wrap edge.
- `msg_ready` drops the cycle after acceptance and rises the cycle after promotion.
- `an` never has two bits low. On every slot change `an` passes through 4'b1111 for exactly `BLANK_CYCLES` cycles.

## Test plan

Bench uses `DIGIT_CYCLES`=8, `BLANK_CYCLES`=2.

1. **Reset state.** Hold `reset` 5 cycles, then release → `an`=1111, `char`=4'hC, `msg_ready`=1, `frame_start`=0. First lit pattern `an`=0111 appears 2 cycles after release.
2. **Scan order.** No message offered → `an` cycles 0111, 1011, 1101, 1110, each preceded by 2 cycles of 1111. Period 32 cycles. `char`=4'hC throughout.
3. **Message load.** Offer 16'h01BA (chars 0,1,F,-) one cycle after release → accepted; `msg_ready`=0 until the wrap edge at cycle 31. Then `frame_start` pulses, `msg_ready`=1, and `char` reads 0, 1, B, A in digits 3, 2, 1, 0 of the second frame.
4. **Backpressure.** Offer 16'h1234 then hold 16'h5678 valid → 5678 is refused until 1234 is promoted. It is accepted the cycle `msg_ready` returns and displayed one frame later. 1234 shows for exactly one full frame.
5. **Wrap-edge accept.** Offer 16'h9999 exactly on the wrap edge → `pend_full`=1; `disp` stays 16'hCCCC for the following frame; 9999 appears after the next wrap.
6. **Reset mid-operation.** Assert `reset` for 1 cycle while `pend_full`=1 and `idx`=1 → all reset values restored; `disp`=16'hCCCC; the pending message is lost.

Source files
------------

// File: rtl/seg_digit_scanner.sv
// rtl/seg_digit_scanner.sv - four-digit 7-segment scanner with double-buffered message and per-slot blanking
module seg_digit_scanner #(
  parameter int DIGIT_CYCLES = 1000,
  parameter int BLANK_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] msg_in,
  input  logic        msg_valid,
  output logic        msg_ready,
  output logic [3:0]  char,
  output logic [3:0]  an,
  output logic        frame_start
);

  localparam int CNT_W = (DIGIT_CYCLES > 2) ? $clog2(DIGIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIGIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [15:0]      disp_q, disp_d;
  logic [15:0]      pend_q, pend_d;
  logic             pend_full_q, pend_full_d;
  logic             frame_start_q, frame_start_d;

  logic slot_end;
  logic wrap;

  // Next-state: slot counter, digit index walking 3..0, and frame-boundary promotion of the pending message
  always_comb begin
    cnt_d         = cnt_q + 1'b1;
    idx_d         = idx_q;
    disp_d        = disp_q;
    pend_d        = pend_q;
    pend_full_d   = pend_full_q;
    frame_start_d = 1'b0;

    slot_end = (cnt_q == CNT_LAST);
    wrap     = slot_end && (idx_q == 2'd0);

    if (slot_end) begin
      cnt_d = '0;
      idx_d = idx_q - 2'd1;
    end

    // Promotion only on the wrap edge keeps a frame from ever being torn
    if (wrap) begin
      frame_start_d = 1'b1;
      if (pend_full_q) begin
        disp_d      = pend_q;
        pend_full_d = 1'b0;
      end
    end

    // Acceptance and promotion are exclusive: accepting needs pend_full_q low
    if (msg_valid && !pend_full_q) begin
      pend_d      = msg_in;
      pend_full_d = 1'b1;
    end
  end

  // State registers with synchronous reset; reset discards scan position and any pending message
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q         <= '0;
      idx_q         <= 2'd3;
      disp_q        <= 16'hCCCC;
      pend_q        <= 16'h0000;
      pend_full_q   <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      disp_q        <= disp_d;
      pend_q        <= pend_d;
      pend_full_q   <= pend_full_d;
      frame_start_q <= frame_start_d;
    end
  end

  // Moore output decode from registered state only; anodes stay dark during the blank window
  always_comb begin
    msg_ready   = !pend_full_q;
    char        = disp_q[{idx_q, 2'b00} +: 4];
    frame_start = frame_start_q;
    if (cnt_q < BLANK_END) begin
      an = 4'b1111;
    end else begin
      an = ~(4'b0001 << idx_q);
    end
  end

endmodule

// File: tb/tb_seg_digit_scanner.sv
// tb/tb_seg_digit_scanner.sv - self-checking bench for seg_digit_scanner
module tb_seg_digit_scanner;

  localparam int DC    = 8;
  localparam int BC    = 2;
  localparam int FRAME = 4 * DC;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] msg_in = 16'h0000;
  logic        msg_valid = 1'b0;
  logic        msg_ready;
  logic [3:0]  char;
  logic [3:0]  an;
  logic        frame_start;

  seg_digit_scanner #(.DIGIT_CYCLES(DC), .BLANK_CYCLES(BC)) dut (
    .clk(clk),
    .reset(reset),
    .msg_in(msg_in),
    .msg_valid(msg_valid),
    .msg_ready(msg_ready),
    .char(char),
    .an(an),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         k;
    logic [3:0] an;
    logic [3:0] ch;
    logic       fs;
    logic       rdy;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] pend_sb[$];
  logic [15:0] exp_disp;
  int          k;
  int          vectors = 0;
  int          miscompares = 0;
  exp_t        e;
  logic        acc;

  function automatic exp_t expect_at(input int kk);
    exp_t r;
    int pos, idx, cnt;
    pos   = kk % FRAME;
    idx   = 3 - pos / DC;
    cnt   = pos % DC;
    r.k   = kk;
    r.an  = (cnt < BC) ? 4'b1111 : ~(4'b0001 << idx);
    r.ch  = exp_disp[4*idx +: 4];
    r.fs  = (kk > 0) && (pos == 0);
    r.rdy = (pend_sb.size() == 0);
    return r;
  endfunction

  task automatic drive(input logic v, input logic [15:0] d, output logic accepted);
    logic rdy;
    rdy = (pend_sb.size() == 0);
    accepted = v && rdy;
    if ((k % FRAME) == FRAME - 1 && !rdy) exp_disp = pend_sb.pop_front();
    else if (accepted) pend_sb.push_back(d);
    msg_valid = v;
    msg_in    = d;
    k++;
    sb.push_back(expect_at(k));
    @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    reset     = 1'b1;
    msg_valid = 1'b0;
    repeat (n) @(negedge clk);
    reset    = 1'b0;
    k        = 0;
    exp_disp = 16'hCCCC;
    pend_sb.delete();
    sb.delete();
    sb.push_back(expect_at(0));
  endtask

  task automatic test_reset;
    do_reset(5);
    vectors++;
    if ({an, char, msg_ready, frame_start} !== {4'b1111, 4'hC, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_state an=%b char=%h rdy=%b fs=%b required an=1111 char=c rdy=1 fs=0",
               an, char, msg_ready, frame_start);
    end
    for (int i = 0; i < 10; i++) begin
      e = sb.pop_front();
      vectors++;
      if ({an, char, frame_start, msg_ready} !== {e.an, e.ch, e.fs, e.rdy}) begin
        miscompares++;
        $display("FAIL reset_run k=%0d an=%b char=%h fs=%b rdy=%b required an=%b char=%h fs=%b rdy=%b",
                 e.k, an, char, frame_start, msg_ready, e.an, e.ch, e.fs, e.rdy);
      end
      if (k == 2) begin
        vectors++;
        if (an !== 4'b0111) begin
          miscompares++;
          $display("FAIL first_lit an=%b required 0111", an);
        end
      end
      drive(1'b0, 16'h0000, acc);
    end
  endtask

  task automatic test_scan;
    do_reset(2);
    for (int i = 0; i < 2 * FRAME + 6; i++) begin
      e = sb.pop_front();
      vectors++;
      if ({an, char, frame_start, msg_ready} !== {e.an, e.ch, e.fs, e.rdy}) begin
        miscompares++;
        $display("FAIL scan k=%0d an=%b char=%h fs=%b rdy=%b required an=%b char=%h fs=%b rdy=%b",
                 e.k, an, char, frame_start, msg_ready, e.an, e.ch, e.fs, e.rdy);
      end
      drive(1'b0, 16'h0000, acc);
    end
  endtask

  task automatic test_load;
    do_reset(1);
    for (int i = 0; i < 2 * FRAME + 4; i++) begin
      e = sb.pop_front();
      vectors++;
      if ({an, char, frame_start, msg_ready} !== {e.an, e.ch, e.fs, e.rdy}) begin
        miscompares++;
        $display("FAIL load k=%0d an=%b char=%h fs=%b rdy=%b required an=%b char=%h fs=%b rdy=%b",
                 e.k, an, char, frame_start, msg_ready, e.an, e.ch, e.fs, e.rdy);
      end
      if (k == 34 || k == 42 || k == 50 || k == 58) begin
        logic [15:0] m;
        logic [3:0]  want;
        m    = 16'h01BA;
        want = m[4*(3 - (k - 32) / DC) +: 4];
        vectors++;
        if (char !== want) begin
          miscompares++;
          $display("FAIL load_digit k=%0d char=%h required %h", k, char, want);
        end
      end
      drive(k == 1, 16'h01BA, acc);
    end
  endtask

  task automatic test_back_to_back;
    logic sent1, sent2;
    int   acc2_k;
    sent1  = 1'b0;
    sent2  = 1'b0;
    acc2_k = -1;
    do_reset(1);
    for (int i = 0; i < 3 * FRAME + 4; i++) begin
      e = sb.pop_front();
      vectors++;
      if ({an, char, frame_start, msg_ready} !== {e.an, e.ch, e.fs, e.rdy}) begin
        miscompares++;
        $display("FAIL backpressure k=%0d an=%b char=%h fs=%b rdy=%b required an=%b char=%h fs=%b rdy=%b",
                 e.k, an, char, frame_start, msg_ready, e.an, e.ch, e.fs, e.rdy);
      end
      drive(!sent2, sent1 ? 16'h5678 : 16'h1234, acc);
      if (acc) begin
        if (!sent1) sent1 = 1'b1;
        else begin
          sent2  = 1'b1;
          acc2_k = k - 1;
        end
      end
    end
    vectors++;
    if (acc2_k != FRAME) begin
      miscompares++;
      $display("FAIL backpressure_accept_cycle got=%0d required=%0d", acc2_k, FRAME);
    end
  endtask

  task automatic test_wrap_accept;
    do_reset(1);
    for (int i = 0; i < 3 * FRAME + 4; i++) begin
      e = sb.pop_front();
      vectors++;
      if ({an, char, frame_start, msg_ready} !== {e.an, e.ch, e.fs, e.rdy}) begin
        miscompares++;
        $display("FAIL wrap_accept k=%0d an=%b char=%h fs=%b rdy=%b required an=%b char=%h fs=%b rdy=%b",
                 e.k, an, char, frame_start, msg_ready, e.an, e.ch, e.fs, e.rdy);
      end
      if (k == 40 || k == 72) begin
        vectors++;
        if (char !== ((k == 40) ? 4'hC : 4'h9)) begin
          miscompares++;
          $display("FAIL wrap_accept_char k=%0d char=%h required %h", k, char, (k == 40) ? 4'hC : 4'h9);
        end
      end
      drive(k == FRAME - 1, 16'h9999, acc);
    end
  endtask

  task automatic test_reset_mid;
    do_reset(1);
    for (int i = 0; i < 18; i++) begin
      e = sb.pop_front();
      vectors++;
      if ({an, char, frame_start, msg_ready} !== {e.an, e.ch, e.fs, e.rdy}) begin
        miscompares++;
        $display("FAIL reset_mid_pre k=%0d an=%b char=%h fs=%b rdy=%b required an=%b char=%h fs=%b rdy=%b",
                 e.k, an, char, frame_start, msg_ready, e.an, e.ch, e.fs, e.rdy);
      end
      drive(k == 3, 16'h4321, acc);
    end
    do_reset(1);
    vectors++;
    if ({an, char, msg_ready, frame_start} !== {4'b1111, 4'hC, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_mid_state an=%b char=%h rdy=%b fs=%b required an=1111 char=c rdy=1 fs=0",
               an, char, msg_ready, frame_start);
    end
    for (int i = 0; i < 2 * FRAME + 4; i++) begin
      e = sb.pop_front();
      vectors++;
      if ({an, char, frame_start, msg_ready} !== {e.an, e.ch, e.fs, e.rdy}) begin
        miscompares++;
        $display("FAIL reset_mid_post k=%0d an=%b char=%h fs=%b rdy=%b required an=%b char=%h fs=%b rdy=%b",
                 e.k, an, char, frame_start, msg_ready, e.an, e.ch, e.fs, e.rdy);
      end
      if (k == 34) begin
        vectors++;
        if (char !== 4'hC) begin
          miscompares++;
          $display("FAIL reset_mid_lost char=%h required c", char);
        end
      end
      drive(1'b0, 16'h0000, acc);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset;
    test_scan;
    test_load;
    test_back_to_back;
    test_wrap_accept;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
